// File: rtl/xor_parity_pkg.sv
// Shared types and helpers for the serial even/odd parity receiver.
package xor_parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // XOR reduction of the supplied bits, inverted when odd parity is selected.
    function automatic logic par_calc(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, one parity bit.
// Define XOR_PARITY_RX_ERR_CNT_EN to add the saturating err_cnt output.
module xor_parity_rx
    import xor_parity_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ODD   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef XOR_PARITY_RX_ERR_CNT_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             par_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            acc;
    logic [WIDTH-1:0] shreg;

    assign out_valid = (state == HOLD);
    assign out_data  = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= 1'b0;
            shreg   <= '0;
            par_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_valid && !bit_in) begin
                        shreg <= '0;
                        cnt   <= '0;
                        acc   <= 1'b0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        // Decoded write avoids an index wider than the data vector.
                        for (int unsigned i = 0; i < WIDTH; i++) begin
                            if (cnt == CW'(i)) shreg[i] <= bit_in;
                        end
                        acc <= acc ^ bit_in;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= PAR;
                    end
                end
                PAR: begin
                    if (bit_valid) begin
                        par_err <= par_calc(32'({acc, bit_in}), 1'(ODD));
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    overrun <= bit_valid;
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef XOR_PARITY_RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (state == HOLD && out_ready && par_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xor_parity_rx.sv
// Directed self-checking bench for xor_parity_rx (WIDTH=4, even and odd instances).
// Honours XOR_PARITY_RX_ERR_CNT_EN to exercise err_cnt when the feature is built.
module tb_xor_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_valid;
    logic       bit_in;
    logic       out_ready;
    logic       vld_e, vld_o;
    logic [3:0] data_e, data_o;
    logic       perr_e, perr_o;
    logic       ovr_e, ovr_o;
`ifdef XOR_PARITY_RX_ERR_CNT_EN
    logic [7:0] ecnt_e, ecnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    xor_parity_rx #(.WIDTH(4), .ODD(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_valid(vld_e), .out_ready(out_ready), .out_data(data_e),
`ifdef XOR_PARITY_RX_ERR_CNT_EN
        .err_cnt(ecnt_e),
`endif
        .par_err(perr_e), .overrun(ovr_e)
    );

    xor_parity_rx #(.WIDTH(4), .ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_valid(vld_o), .out_ready(out_ready), .out_data(data_o),
`ifdef XOR_PARITY_RX_ERR_CNT_EN
        .err_cnt(ecnt_o),
`endif
        .par_err(perr_o), .overrun(ovr_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one sampled bit for a cycle, then gap idle cycles with bit_valid low.
    task automatic send_bit(input logic b, input int gap);
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 4; i++) send_bit(d[i], gap);
        send_bit(p, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_vld", 32'(vld_e), 32'd0);
        check("rst_data", 32'(data_e), 32'd0);
        check("rst_perr", 32'(perr_e), 32'd0);
        check("rst_ovr", 32'(ovr_e), 32'd0);
`ifdef XOR_PARITY_RX_ERR_CNT_EN
        check("rst_ecnt", 32'(ecnt_e), 32'd0);
`endif
        rst_n = 1'b1;

        // 0xB, parity 1: good even parity, bad odd parity
        send_frame(4'hB, 1'b1, 0);
        check("f1_vld", 32'(vld_e), 32'd1);
        check("f1_data", 32'(data_e), 32'hB);
        check("f1_perr_e", 32'(perr_e), 32'd0);
        check("f1_perr_o", 32'(perr_o), 32'd1);
        @(negedge clk);
        check("f1_vld_drop", 32'(vld_e), 32'd0);

        // 0xB, parity 0: bad even parity
        send_frame(4'hB, 1'b0, 0);
        check("f2_data", 32'(data_e), 32'hB);
        check("f2_perr_e", 32'(perr_e), 32'd1);
        check("f2_perr_o", 32'(perr_o), 32'd0);
        @(negedge clk);
`ifdef XOR_PARITY_RX_ERR_CNT_EN
        check("f2_ecnt", 32'(ecnt_e), 32'd1);
`endif

        // 0x0 with parity 1 then 0
        send_frame(4'h0, 1'b1, 0);
        check("f3_data", 32'(data_o), 32'h0);
        check("f3_perr_o", 32'(perr_o), 32'd0);
        check("f3_perr_e", 32'(perr_e), 32'd1);
        @(negedge clk);
        send_frame(4'h0, 1'b0, 0);
        check("f4_perr_o", 32'(perr_o), 32'd1);
        check("f4_perr_e", 32'(perr_e), 32'd0);
        @(negedge clk);

        // Back-pressure: bits arriving in HOLD are dropped with overrun pulses
        out_ready = 1'b0;
        send_frame(4'h3, 1'b0, 0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            bit_valid = (k % 2 == 0);
            bit_in    = 1'b0;
            @(negedge clk);
            if (ovr_e) pulses++;
        end
        bit_valid = 1'b0;
        check("bp_vld_held", 32'(vld_e), 32'd1);
        check("bp_data_held", 32'(data_e), 32'h3);
        check("bp_perr_held", 32'(perr_e), 32'd0);
        check("bp_pulses", 32'(pulses), 32'd3);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_vld_drop", 32'(vld_e), 32'd0);
        check("bp_ovr_clear", 32'(ovr_e), 32'd0);
        send_frame(4'h5, 1'b0, 0);
        check("bp_next_data", 32'(data_e), 32'h5);
        check("bp_next_perr", 32'(perr_e), 32'd0);
        @(negedge clk);

        // Asynchronous reset mid-frame
        send_frame(4'hB, 1'b0, 0);
        @(negedge clk);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("mid_partial", 32'(data_e), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", 32'(vld_e), 32'd0);
        check("arst_data", 32'(data_e), 32'd0);
        check("arst_perr", 32'(perr_e), 32'd0);
`ifdef XOR_PARITY_RX_ERR_CNT_EN
        check("arst_ecnt", 32'(ecnt_e), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(4'h6, 1'b0, 0);
        check("post_rst_vld", 32'(vld_e), 32'd1);
        check("post_rst_data", 32'(data_e), 32'h6);
        check("post_rst_perr", 32'(perr_e), 32'd0);
        @(negedge clk);

        // Leading idle 1s and inter-bit gaps
        for (int k = 0; k < 3; k++) send_bit(1'b1, 1);
        check("idle_ones_vld", 32'(vld_e), 32'd0);
        send_frame(4'hB, 1'b1, 3);
        check("gap_vld", 32'(vld_e), 32'd1);
        check("gap_data", 32'(data_e), 32'hB);
        check("gap_perr_e", 32'(perr_e), 32'd0);
        check("gap_perr_o", 32'(perr_o), 32'd1);
        @(negedge clk);
        check("gap_vld_drop", 32'(vld_e), 32'd0);

`ifdef XOR_PARITY_RX_ERR_CNT_EN
        for (int n = 0; n < 300; n++) begin
            send_frame(4'hB, 1'b0, 0);
            @(negedge clk);
        end
        check("ecnt_sat", 32'(ecnt_e), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_parity_rx.md
XOR_PARITY_RX -- requirements
Module: xor_parity_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the number of data bits per frame (legal 2..32).
REQ-002 SHALL have parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port bit_valid, input, 1 bit: bit_in is sampled this cycle.
REQ-006 SHALL have port bit_in, input, 1 bit: serial frame bit.
REQ-007 SHALL have port out_valid, output, 1 bit: a received word is held on out_data.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-009 SHALL have port out_data, output, WIDTH bits: the received data word.
REQ-010 SHALL have port par_err, output, 1 bit: the parity check failed for the held word; valid only while out_valid is high.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a sampled bit is dropped.

Function
REQ-012 SHALL implement an FSM with states IDLE, DATA, PAR and HOLD.
REQ-013 IDLE: a sampled bit_in=0 (start bit) SHALL clear the shift register and bit counter and enter DATA; a sampled bit_in=1 SHALL be ignored.
REQ-014 DATA: each sampled bit SHALL be stored LSB first at index count and XOR-accumulated; after WIDTH bits the FSM SHALL enter PAR.
REQ-015 PAR: the sampled bit SHALL set par_err = acc ^ bit ^ ODD, and the FSM SHALL enter HOLD.
REQ-016 out_valid SHALL rise in the cycle after the parity bit is sampled (latency 1 cycle).
REQ-017 HOLD: out_valid=1; out_data and par_err SHALL remain stable until out_valid && out_ready, then the FSM SHALL enter IDLE.
REQ-018 A bit sampled in HOLD, including in the transfer cycle, SHALL be dropped and overrun SHALL pulse high for 1 cycle.
REQ-019 Cycles with bit_valid=0 SHALL not advance DATA or PAR; inter-bit gaps have no length limit.
REQ-020 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL not wrap within a frame.
REQ-021 out_ready while not in HOLD SHALL have no effect.

Reset
REQ-022 Assertion of rst_n=0 SHALL immediately force IDLE, out_valid=0, out_data=0, par_err=0, overrun=0, counter=0 and accumulator=0, including mid-frame and in HOLD.
REQ-023 Reset deassertion SHALL be synchronized externally; the first frame may start in the first cycle after deassertion.

Configuration
REQ-024 Macro XOR_PARITY_RX_ERR_CNT_EN defined: SHALL add output err_cnt [7:0], reset to 0.
REQ-025 With the macro defined: err_cnt SHALL increment by 1 for each word transferred with par_err=1 and SHALL saturate at 255.
REQ-026 With the macro undefined: the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package xor_parity_pkg SHALL hold the FSM state enum (IDLE, DATA, PAR, HOLD), 2 bits wide.
REQ-028 Package xor_parity_pkg SHALL hold the function par_calc(data, odd), which returns the XOR reduction of data XOR odd.
REQ-029 The design SHALL have no sub-modules; the parity accumulator is a single flop in xor_parity_rx.

Verification (WIDTH=4)
REQ-030 ODD=0: serial 0,1,1,0,1,1 (start, data 1101 LSB-first = 0xB, parity 1) with out_ready=1 -> out_valid for 1 cycle, out_data=0xB, par_err=0.
REQ-031 ODD=0: same frame with parity 0 -> out_data=0xB, par_err=1; with macro, err_cnt goes 0->1.
REQ-032 ODD=1: start, data 0x0, parity 1 -> par_err=0; parity 0 -> par_err=1.
REQ-033 out_ready=0 for 5 cycles after a frame, with 3 bits sampled meanwhile -> out_data stable, overrun pulses 3 times, and the next start bit after the transfer is received correctly.
REQ-034 rst_n pulsed low after 2 data bits -> outputs 0 at once, and the next full frame decodes correctly.
REQ-035 Leading idle 1s and gaps with bit_valid=0 between bits -> same result as the gapless frame; with macro, 300 error frames -> err_cnt=255.
